// File: rtl/rei_pkg.sv
// Shared rei core definitions: data-bus widths and CLINT register map.
package rei_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned XBYTES = XLEN / 8;

    // CLINT register offsets within the 64 KiB window
    localparam logic [15:0] CLINT_MSIP_OFS     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFS = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFS    = 16'hBFF8;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI
    } clint_reg_e;

    // Replace the strobed bytes of old_word with those of new_word
    function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0]   old_word,
                                                    input logic [XLEN-1:0]   new_word,
                                                    input logic [XBYTES-1:0] strb);
        logic [XLEN-1:0] r;
        r = old_word;
        for (int unsigned b = 0; b < XBYTES; b++) begin
            if (strb[b]) r[8*b +: 8] = new_word[8*b +: 8];
        end
        return r;
    endfunction

    // Map a window offset to a register; byte-lane bits [1:0] are ignored
    function automatic clint_reg_e clint_decode(input logic [15:0] ofs);
        logic [15:0] word_ofs;
        word_ofs = {ofs[15:2], 2'b00};
        case (word_ofs)
            CLINT_MSIP_OFS:                 return REG_MSIP;
            CLINT_MTIMECMP_OFS:             return REG_CMP_LO;
            CLINT_MTIMECMP_OFS + 16'd4:     return REG_CMP_HI;
            CLINT_MTIME_OFS:                return REG_TIME_LO;
            CLINT_MTIME_OFS + 16'd4:        return REG_TIME_HI;
            default:                        return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// mtime prescaler: counts 0..TickDiv-1 and flags the wrap cycle.
module clint_prescaler #(
    parameter int unsigned TickDiv = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned     CntW   = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TickDiv - 1);

    logic [CntW-1:0] cnt;

    assign tick_o = (cnt == CntMax);

    // Free-running divide counter, wraps after TickDiv cycles
    always_ff @(posedge clk_i) begin
        if (rst_i)       cnt <= '0;
        else if (tick_o) cnt <= '0;
        else             cnt <= cnt + CntW'(1);
    end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: msip, mtimecmp and 64-bit mtime on the data bus.
module clint_timer
    import rei_pkg::*;
#(
    parameter logic [XLEN-1:0] BaseAddr = 32'h0200_0000,
    parameter int unsigned     TickDiv  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic              arvalid_i,
    input  logic              wvalid_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XBYTES-1:0] wstrb_i,
    output logic              sel_o,
    output logic [XLEN-1:0]   rdata_o,
    output logic              mtip_o,
    output logic              msip_o
);

    logic [63:0]     mtime;
    logic [63:0]     mtimecmp;
    logic            msip;
    logic            tick;
    logic            wr_en;
    clint_reg_e      reg_sel;
    logic [XLEN-1:0] rd_word;
    logic [XLEN-1:0] wr_word;

    clint_prescaler #(.TickDiv(TickDiv)) u_prescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (tick)
    );

    assign sel_o   = (addr_i[XLEN-1:16] == BaseAddr[XLEN-1:16]);
    assign reg_sel = sel_o ? clint_decode(addr_i[15:0]) : REG_NONE;
    // An all-zero strobe is treated as no write at all, so it never blocks a tick
    assign wr_en   = wvalid_i && sel_o && (wstrb_i != '0);
    // Merge against the current word; rd_word doubles as the pre-write value
    assign wr_word = merge_bytes(rd_word, wdata_i, wstrb_i);

    // Current value of the addressed register (zero for unmapped / out of window)
    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_MSIP:    rd_word = {{(XLEN-1){1'b0}}, msip};
            REG_CMP_LO:  rd_word = mtimecmp[31:0];
            REG_CMP_HI:  rd_word = mtimecmp[63:32];
            REG_TIME_LO: rd_word = mtime[31:0];
            REG_TIME_HI: rd_word = mtime[63:32];
            default:     rd_word = '0;
        endcase
    end

    // Software-writable registers and the registered read/interrupt outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            msip     <= 1'b0;
            mtimecmp <= '1;
            rdata_o  <= '0;
            mtip_o   <= 1'b0;
            msip_o   <= 1'b0;
        end else begin
            rdata_o <= arvalid_i ? rd_word : '0;
            mtip_o  <= (mtime >= mtimecmp);
            msip_o  <= msip;
            if (wr_en) begin
                case (reg_sel)
                    REG_MSIP:   msip            <= wr_word[0];
                    REG_CMP_LO: mtimecmp[31:0]  <= wr_word;
                    REG_CMP_HI: mtimecmp[63:32] <= wr_word;
                    default:    ;
                endcase
            end
        end
    end

    // mtime: a bus write to either half wins over (and swallows) the tick
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime <= '0;
        end else if (wr_en && reg_sel == REG_TIME_LO) begin
            mtime <= {mtime[63:32], wr_word};
        end else if (wr_en && reg_sel == REG_TIME_HI) begin
            mtime <= {wr_word, mtime[31:0]};
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule
